// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: clears the memory, streams num_words_i words into it, then releases the core.
// Optional running checksum output is enabled by defining LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'h0000_0004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_req_i,
  input  logic [7:0]  num_words_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        reset_inst_mem_o,
  output logic        wr_inst_mem_o,
  output logic [31:0] write_inst_addr_o,
  output logic [31:0] write_inst_data_o,
  output logic        start_o,
  output logic        load_done_o,
  output logic        busy_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  num_q, num_d;
  logic [7:0]  idx_q, idx_d;
  logic        accept_s;
  logic        xfer_s;
  logic [31:0] addr_s;

  logic        in_ready_q;
  logic        reset_mem_q;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        start_q;
  logic        done_q;
  logic        busy_q;

  assign accept_s = load_req_i && (num_words_i != 8'd0);
  assign addr_s   = BASE_ADDR + ({24'd0, idx_q} * ADDR_STEP);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    idx_d   = idx_q;
    xfer_s  = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept_s) begin
          state_d = S_CLR;
          num_d   = num_words_i;
          idx_d   = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_CLR: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        xfer_s = in_valid_i;
        if (in_valid_i) begin
          // idx_q tops out at num_q-1 (<= 254), so the increment never wraps
          idx_d = idx_q + 8'd1;
          if (idx_q == (num_q - 8'd1)) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      num_q   <= 8'd0;
      idx_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
    end
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_ready_q  <= 1'b0;
      reset_mem_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == S_LOAD);
      reset_mem_q <= (state_d == S_CLR);
      start_q     <= (state_d == S_RUN);
      done_q      <= (state_q == S_FLUSH);
      busy_q      <= (state_d == S_CLR) || (state_d == S_LOAD) || (state_d == S_FLUSH);
    end
  end

  // Write port: pulse on the cycle after each transfer, address/data hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= 1'b0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end else begin
      wr_q <= xfer_s;
      if (xfer_s) begin
        addr_q <= addr_s;
        data_q <= in_data_i;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cksum_q;

  // Cleared on entry to CLR so it reads zero during the clear cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cksum_q <= 32'd0;
    end else if (state_d == S_CLR) begin
      cksum_q <= 32'd0;
    end else if (xfer_s) begin
      cksum_q <= cksum_q + in_data_i;
    end
  end

  assign checksum_o = cksum_q;
`endif

  assign in_ready_o        = in_ready_q;
  assign reset_inst_mem_o  = reset_mem_q;
  assign wr_inst_mem_o     = wr_q;
  assign write_inst_addr_o = addr_q;
  assign write_inst_data_o = data_q;
  assign start_o           = start_q;
  assign load_done_o       = done_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: table of loads plus reset/ignore sequences, with a write scoreboard.
// Two instances share stimulus: base 0 and base 0xFFFFFFFC (address wrap).
module tb_inst_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_req, in_valid;
  logic [7:0]  num_words;
  logic [31:0] in_data;
  logic        in_ready, res_mem, wr, start, load_done, busy;
  logic [31:0] waddr, wdata;
  logic        in_ready2, res_mem2, wr2, start2, load_done2, busy2;
  logic [31:0] waddr2, wdata2;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cksum, cksum2;
`endif

  inst_mem_loader dut (
    .clk_i(clk), .rst_i(rst), .load_req_i(load_req), .num_words_i(num_words),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .reset_inst_mem_o(res_mem), .wr_inst_mem_o(wr), .write_inst_addr_o(waddr),
    .write_inst_data_o(wdata), .start_o(start), .load_done_o(load_done), .busy_o(busy)
`ifdef LOADER_CHECKSUM_EN
    , .checksum_o(cksum)
`endif
  );

  inst_mem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .ADDR_STEP(32'd4)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .load_req_i(load_req), .num_words_i(num_words),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready2),
    .reset_inst_mem_o(res_mem2), .wr_inst_mem_o(wr2), .write_inst_addr_o(waddr2),
    .write_inst_data_o(wdata2), .start_o(start2), .load_done_o(load_done2), .busy_o(busy2)
`ifdef LOADER_CHECKSUM_EN
    , .checksum_o(cksum2)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] addr2;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    logic [7:0]  n;
    int          gap_at;
    int          gap_len;
    logic [31:0] d0;
    logic [31:0] dstep;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_cksum;
  } vec_t;

  wr_exp_t     sb_q[$];
  wr_exp_t     mon_e;
  vec_t        vecs[6];
  int          checks = 0;
  int          failures = 0;
  int          wr_count = 0;
  logic [31:0] last_addr = 32'd0;

  // Scoreboard: every write on either instance must match the oldest expected transfer.
  always @(negedge clk) begin
    if (wr || wr2) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: wr=%0b wr2=%0b addr=%h data=%h, required no write", wr, wr2, waddr, wdata);
      end else begin
        mon_e = sb_q.pop_front();
        if (!(wr && wr2 && waddr == mon_e.addr && wdata == mon_e.data &&
              waddr2 == mon_e.addr2 && wdata2 == mon_e.data)) begin
          failures++;
          $display("FAIL write: got wr=%0b/%0b addr=%h/%h data=%h/%h, required addr=%h/%h data=%h",
                   wr, wr2, waddr, waddr2, wdata, wdata2, mon_e.addr, mon_e.addr2, mon_e.data);
        end
        wr_count++;
        last_addr = waddr;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int i, input logic [31:0] d);
    wr_exp_t e;
    e.addr  = 32'(i) * 32'd4;
    e.addr2 = 32'hFFFF_FFFC + 32'(i) * 32'd4;
    e.data  = d;
    sb_q.push_back(e);
  endtask

  task automatic do_load(input vec_t v);
    int          wc0;
    logic [31:0] d;
    wc0 = wr_count;
    load_req = 1'b1;
    num_words = v.n;
    step();
    load_req = 1'b0;
    chk1("clr_pulse", res_mem, 1'b1);
    chk1("clr_busy", busy, 1'b1);
    chk1("clr_start_low", start, 1'b0);
    chk1("clr_ready_low", in_ready, 1'b0);
    step();
    chk1("clr_one_cycle", res_mem, 1'b0);
    chk1("load_ready", in_ready, 1'b1);
    for (int i = 0; i < int'(v.n); i++) begin
      if (i == v.gap_at) begin
        for (int g = 0; g < v.gap_len; g++) begin
          in_valid = 1'b0;
          load_req = 1'b1;
          num_words = 8'd7;
          step();
          chk1("gap_no_write", wr, 1'b0);
          chk1("gap_ready", in_ready, 1'b1);
        end
        load_req = 1'b0;
      end
      d = v.d0 + 32'(i) * v.dstep;
      in_valid = 1'b1;
      in_data = d;
      push_word(i, d);
      step();
    end
    in_valid = 1'b0;
    chk1("flush_ready_low", in_ready, 1'b0);
    chk1("flush_busy", busy, 1'b1);
    chk1("flush_start_low", start, 1'b0);
    step();
    chk1("run_start", start, 1'b1);
    chk1("run_done", load_done, 1'b1);
    chk1("run_busy_low", busy, 1'b0);
    chk1("run_no_write", wr, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", cksum, v.exp_cksum);
`endif
    step();
    chk1("done_one_cycle", load_done, 1'b0);
    chk1("start_hold", start, 1'b1);
    chk("write_count", 32'(wr_count - wc0), 32'(v.n));
    chk("last_addr", last_addr, v.exp_last_addr);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_ready"}, in_ready, 1'b0);
    chk1({tag, "_resmem"}, res_mem, 1'b0);
    chk1({tag, "_wr"}, wr, 1'b0);
    chk({tag, "_addr"}, waddr, 32'd0);
    chk({tag, "_data"}, wdata, 32'd0);
    chk1({tag, "_start"}, start, 1'b0);
    chk1({tag, "_done"}, load_done, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    chk({tag, "_cksum"}, cksum, 32'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{8'd3,   -1, 0, 32'h11,        32'h11,  32'h8,   32'h66};
    vecs[1] = '{8'd3,    2, 2, 32'h11,        32'h11,  32'h8,   32'h66};
    vecs[2] = '{8'd1,   -1, 0, 32'hDEADBEEF,  32'h0,   32'h0,   32'hDEADBEEF};
    vecs[3] = '{8'd2,   -1, 0, 32'hFFFFFFFF,  32'h3,   32'h4,   32'h1};
    vecs[4] = '{8'd5,    1, 1, 32'h1000,      32'h101, 32'h10,  32'h5A0A};
    vecs[5] = '{8'd255, -1, 0, 32'h0,         32'h1,   32'h3F8, 32'h7E81};

    rst = 1'b1;
    load_req = 1'b0;
    num_words = 8'd0;
    in_valid = 1'b0;
    in_data = 32'd0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    load_req = 1'b1;
    num_words = 8'd0;
    step();
    load_req = 1'b0;
    chk1("zero_idle_busy", busy, 1'b0);
    chk1("zero_idle_resmem", res_mem, 1'b0);
    step();
    chk1("zero_idle_busy2", busy, 1'b0);

    // Loads run back to back, so every load after the first is a reload from RUN.
    for (int k = 0; k < 6; k++) begin
      do_load(vecs[k]);
    end

    load_req = 1'b1;
    num_words = 8'd0;
    step();
    load_req = 1'b0;
    chk1("zero_run_start", start, 1'b1);
    chk1("zero_run_busy", busy, 1'b0);
    chk1("zero_run_resmem", res_mem, 1'b0);

    // Abort a 5-word load after two transfers; reset wins over a same-edge transfer.
    load_req = 1'b1;
    num_words = 8'd5;
    step();
    load_req = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 32'hA0 + 32'(i);
      push_word(i, 32'hA0 + 32'(i));
      step();
    end
    in_data = 32'hBAD;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("abort");
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("abort_no_write", wr, 1'b0);
      chk1("abort_idle", busy, 1'b0);
    end
    in_valid = 1'b0;
    chk("abort_sb", 32'(sb_q.size()), 32'd0);

    do_load(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: instMemLoader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 0, byte address of the first instruction word written.
REQ-002 SHALL have parameter ADDR_STEP, default 4, byte increment between consecutive words.
REQ-003 clk  in  1  the only clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 loadReq  in  1  request to start a program load; sampled only in IDLE or RUN.
REQ-006 numWords  in  8  number of words to load; latched when loadReq is accepted.
REQ-007 inValid  in  1 and inData  in  32  source word stream; a transfer occurs on an edge where inValid and inReady are both 1.
REQ-008 inReady  out  1  the loader accepts a word this cycle.
REQ-009 resetInstMem  out  1  clear pulse to the instruction memory.
REQ-010 wrInstMem, writeInstAddr[31:0], writeInstData[31:0]  out  instruction-memory write port; all three are registered.
REQ-011 start  out  1  level that releases the control unit; loadDone  out  1  one-cycle completion pulse; busy  out  1  high in CLR, LOAD and FLUSH.

Function
REQ-012 FSM states SHALL be IDLE, CLR, LOAD, FLUSH and RUN.
REQ-013 IDLE: on loadReq=1 with numWords!=0, latch numWords, clear the word index, and go to CLR; loadReq with numWords=0 SHALL be ignored.
REQ-014 CLR SHALL last exactly one cycle with resetInstMem=1, then go to LOAD.
REQ-015 LOAD: inReady=1 every cycle; each transfer SHALL register, at the same edge, wrInstMem=1, writeInstAddr=BASE_ADDR+index*ADDR_STEP (mod 2^32), and writeInstData=inData, then increment the index.
REQ-016 wrInstMem SHALL be 0 in every cycle not immediately following a transfer; writeInstAddr and writeInstData SHALL hold their last values.
REQ-017 Consequently, write latency SHALL be one cycle from the accepting edge, and back-to-back transfers SHALL produce back-to-back writes.
REQ-018 On the transfer of word numWords-1, the FSM SHALL go to FLUSH, and inReady SHALL be 0 from the next cycle onward.
REQ-019 FLUSH SHALL last one cycle, during which the final write is presented; then go to RUN with start=1 and loadDone=1 for that first RUN cycle.
REQ-020 RUN: start SHALL hold at 1; loadReq with numWords!=0 SHALL drop start at the next edge and enter CLR (reload); otherwise loadReq is ignored.
REQ-021 loadReq in CLR, LOAD or FLUSH SHALL be ignored.
REQ-022 numWords=255 SHALL load 255 words; the index is 8 bits and SHALL never wrap within a load.
REQ-023 inValid deasserted mid-load SHALL stall the load indefinitely, with no write and no timeout.

Reset
REQ-024 rst=1 SHALL force IDLE and clear every output to 0: inReady, resetInstMem, wrInstMem, writeInstAddr, writeInstData, start, loadDone, busy, and checksum.
REQ-025 rst asserted mid-load SHALL abort the load with no further writes; words already written SHALL remain in memory.
REQ-026 rst SHALL take priority over loadReq and transfers on the same edge.

Configuration
REQ-027 With LOADER_CHECKSUM_EN defined, the block SHALL add output checksum[31:0], cleared in CLR and incremented by inData (mod 2^32) on every transfer, and stable from FLUSH onward.
REQ-028 Without LOADER_CHECKSUM_EN, the checksum port and its adder SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then loadReq with numWords=3 and words 0x11,0x22,0x33 streamed continuously -> resetInstMem for one cycle; writes (0,0x11), (4,0x22), (8,0x33) on consecutive cycles; start and loadDone rise one cycle after the last write.
REQ-030 Same load with inValid low for 2 cycles between words 1 and 2 -> exactly 3 writes at addresses 0, 4 and 8; no write during the gap.
REQ-031 With BASE_ADDR=0xFFFFFFFC, load of 2 words -> addresses 0xFFFFFFFC then 0x00000000.
REQ-032 rst asserted after the 2nd transfer of a 5-word load -> all outputs 0 on the next cycle, no further wrInstMem, and a subsequent loadReq runs a full load.
REQ-033 In RUN, loadReq with numWords=1 and word 0xDEADBEEF -> start drops, resetInstMem pulses, write (0,0xDEADBEEF) occurs, then start rises again.
REQ-034 LOADER_CHECKSUM_EN defined, words 0xFFFFFFFF and 0x2 -> checksum=0x00000001; loadReq with numWords=0 in IDLE -> no state change.
